// File: rtl/load_byte_sequencer_if.sv
// Request/result bundle for the load-data byte sequencer.
interface load_byte_sequencer_if;
  logic        start;
  logic [63:0] mem_word;
  logic [2:0]  offset;
  logic [1:0]  size;
  logic        uns;
  logic        busy;
  logic        done;
  logic [63:0] data_out;
  logic        misaligned;

  modport master (
    output start, mem_word, offset, size, uns,
    input  busy, done, data_out, misaligned
  );

  modport slave (
    input  start, mem_word, offset, size, uns,
    output busy, done, data_out, misaligned
  );
endinterface

// File: rtl/load_byte_sequencer.sv
// Byte-serial load extractor: one lane per cycle, then sign/zero extend.
// Optional MISALIGN_TRAP_EN: misaligned requests finish at once with a flag.
module load_byte_sequencer (
  input  logic clk,
  input  logic reset,
  load_byte_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FINISH
  } state_t;

  state_t      r_state;
  logic [63:0] r_word;
  logic [2:0]  r_sel;
  logic [2:0]  r_k;
  logic [3:0]  r_rem;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [63:0] r_res;
  logic [63:0] r_data;
  logic        r_busy;
  logic        r_done;
  logic        r_mis;

  logic [7:0]  w_lane;
  logic [63:0] w_asm;
  logic [63:0] w_ext;
  logic [3:0]  w_n;
  logic        w_last;
  logic        w_fill;

  // internal 8:1 byte mux
  assign w_lane = r_word[{r_sel, 3'b000} +: 8];
  assign w_last = (r_rem == 4'd1);
  assign w_n    = 4'd1 << bus.size;

  always_comb begin
    w_asm = r_res;
    w_asm[{r_k, 3'b000} +: 8] = w_lane;
    w_ext  = w_asm;
    w_fill = 1'b0;
    unique case (r_size)
      2'b00: begin
        w_fill      = ~r_uns & w_asm[7];
        w_ext[63:8] = {56{w_fill}};
      end
      2'b01: begin
        w_fill       = ~r_uns & w_asm[15];
        w_ext[63:16] = {48{w_fill}};
      end
      2'b10: begin
        w_fill       = ~r_uns & w_asm[31];
        w_ext[63:32] = {32{w_fill}};
      end
      2'b11: begin
        w_fill = 1'b0;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic [2:0] w_mask;
  logic       w_misal;

  always_comb begin
    w_mask = 3'b000;
    unique case (bus.size)
      2'b00: w_mask = 3'b000;
      2'b01: w_mask = 3'b001;
      2'b10: w_mask = 3'b011;
      2'b11: w_mask = 3'b111;
    endcase
  end

  assign w_misal = |(bus.offset & w_mask);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= 64'h0;
      r_sel   <= 3'd0;
      r_k     <= 3'd0;
      r_rem   <= 4'd0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_res   <= 64'h0;
      r_data  <= 64'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_word  <= bus.mem_word;
            r_size  <= bus.size;
            r_uns   <= bus.uns;
            r_sel   <= bus.offset;
            r_k     <= 3'd0;
            r_rem   <= w_n;
            r_res   <= 64'h0;
            r_busy  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (w_misal) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_mis   <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
            end
`else
            r_state <= S_COLLECT;
`endif
          end
        end
        S_COLLECT: begin
          r_res <= w_asm;
          r_sel <= r_sel + 3'd1;
          r_k   <= r_k + 3'd1;
          r_rem <= r_rem - 4'd1;
          if (w_last) begin
            r_data  <= w_ext;
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.data_out   = r_data;
  assign bus.misaligned = r_mis;

endmodule

// File: tb/tb_load_byte_sequencer.sv
// Directed vector bench for load_byte_sequencer.
// Honours MISALIGN_TRAP_EN when choosing expected results.
module tb_load_byte_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  load_byte_sequencer_if bus ();

  load_byte_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] MW = 64'h8877_6655_4433_2211;

  typedef struct {
    logic [1:0]  size;
    logic [2:0]  off;
    logic        uns;
    logic [63:0] word;
    bit          inject;
    logic [63:0] exp_data;
    int          exp_lat;
    logic        exp_mis;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run(input vec_t v, output int lat,
                     output logic [63:0] d, output logic mis,
                     output bit busy_ok);
    int cyc;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mem_word = v.word;
    bus.offset   = v.off;
    bus.size     = v.size;
    bus.uns      = v.uns;
    lat = -1;
    d = 64'hx;
    mis = 1'bx;
    busy_ok = 1'b1;
    cyc = 0;
    while (lat < 0 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = cyc;
        d   = bus.data_out;
        mis = bus.misaligned;
      end else begin
        @(negedge clk);
        if (v.inject && cyc == 1) begin
          bus.start    = 1'b1;
          bus.mem_word = ~v.word;
          bus.offset   = 3'd0;
          bus.size     = 2'b11;
          bus.uns      = ~v.uns;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  vec_t vt[9];
  int lat;
  logic [63:0] d;
  logic mis;
  bit bok;

  initial begin
    vt[0] = '{2'b00, 3'd7, 1'b0, MW, 1'b0,
              64'hFFFF_FFFF_FFFF_FF88, 2, 1'b0};
    vt[1] = '{2'b01, 3'd2, 1'b1, MW, 1'b1,
              64'h0000_0000_0000_4433, 3, 1'b0};
    vt[2] = '{2'b10, 3'd4, 1'b0, MW, 1'b0,
              64'hFFFF_FFFF_8877_6655, 5, 1'b0};
    vt[3] = '{2'b10, 3'd4, 1'b1, MW, 1'b0,
              64'h0000_0000_8877_6655, 5, 1'b0};
    vt[4] = '{2'b11, 3'd0, 1'b1, MW, 1'b0, MW, 9, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vt[5] = '{2'b01, 3'd7, 1'b1, MW, 1'b0, MW, 1, 1'b1};
`else
    vt[5] = '{2'b01, 3'd7, 1'b1, MW, 1'b0,
              64'h0000_0000_0000_1188, 3, 1'b0};
`endif
    vt[6] = '{2'b00, 3'd3, 1'b1, MW, 1'b0,
              64'h0000_0000_0000_0044, 2, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vt[7] = '{2'b10, 3'd6, 1'b0, MW, 1'b0,
              64'h0000_0000_0000_0044, 1, 1'b1};
`else
    vt[7] = '{2'b10, 3'd6, 1'b0, MW, 1'b0,
              64'h0000_0000_2211_8877, 5, 1'b0};
`endif
    vt[8] = '{2'b01, 3'd4, 1'b0, 64'hAAAA_80FF_0000_0000, 1'b0,
              64'hFFFF_FFFF_FFFF_80FF, 3, 1'b0};

    bus.start    = 1'b0;
    bus.mem_word = 64'h0;
    bus.offset   = 3'd0;
    bus.size     = 2'b00;
    bus.uns      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_mis", {63'd0, bus.misaligned}, 64'd0);
    check("reset_data", bus.data_out, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run(vt[i], lat, d, mis, bok);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
      check($sformatf("v%0d_data", i), d, vt[i].exp_data);
      check($sformatf("v%0d_mis", i), {63'd0, mis}, {63'd0, vt[i].exp_mis});
      check($sformatf("v%0d_busy", i), {63'd0, bok}, 64'd1);
      // cycle after done: idle, pulse over, result held
      @(posedge clk);
      #1;
      check($sformatf("v%0d_idle", i),
            {62'd0, bus.busy, bus.done}, 64'd0);
      check($sformatf("v%0d_hold", i), bus.data_out, vt[i].exp_data);
    end

    // reset in cycle 4 of a double
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mem_word = MW;
    bus.offset   = 3'd0;
    bus.size     = 2'b11;
    bus.uns      = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_data", bus.data_out, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    run('{2'b00, 3'd0, 1'b0, MW, 1'b0, 64'h11, 2, 1'b0},
        lat, d, mis, bok);
    check("post_rst_lat", 64'(lat), 64'd2);
    check("post_rst_data", d, 64'h11);
    check("post_rst_mis", {63'd0, mis}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
